rob_retire: RTL and testbench

- In-order reorder buffer and retire unit for the OoO core.
- Rename allocates one entry per instruction, carrying the destination areg, the new preg and the previous preg mapping of rd.
- Writeback marks entries complete.
- Retire drains the head in program order, reporting the committed mapping and returning the stale preg to the free pool. This is the release path feeding the free pool's push_free_reg/freed_reg.

---
 rtl/rename_pkg.sv | 20 ++
 rtl/rob_ptr_ctrl.sv | 54 +++++
 rtl/rob_retire.sv | 124 ++++++++++++
 tb/tb_rob_retire.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared rename/ROB widths, tag types and ROB entry layout
package rename_pkg;

    localparam int PREG_WIDTH = 6;
    localparam int AREG_WIDTH = 5;
    localparam int ROB_DEPTH  = 16;

    typedef logic [PREG_WIDTH-1:0] preg_t;
    typedef logic [AREG_WIDTH-1:0] areg_t;

    typedef struct packed {
        logic  valid;
        logic  done;
        logic  reg_write;
        areg_t rd;
        preg_t prd;
        preg_t old_prd;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// rtl/rob_ptr_ctrl.sv - ROB head/tail pointers and occupancy with full/empty
module rob_ptr_ctrl #(
    parameter int DEPTH     = 16,
    parameter int IDX_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_fire,
    input  logic                 retire_fire,
    output logic [IDX_WIDTH-1:0] head,
    output logic [IDX_WIDTH-1:0] tail,
    output logic [IDX_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty
);

    logic [IDX_WIDTH-1:0] head_q, head_d;
    logic [IDX_WIDTH-1:0] tail_q, tail_d;
    logic [IDX_WIDTH:0]   count_q, count_d;

    // Pointers wrap naturally at DEPTH (power of two); count tracks the difference.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (retire_fire) head_d = head_q + IDX_WIDTH'(1);
        if (alloc_fire)  tail_d = tail_q + IDX_WIDTH'(1);
        case ({alloc_fire, retire_fire})
            2'b10:   count_d = count_q + (IDX_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (IDX_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign tail  = tail_q;
    assign count = count_q;
    assign full  = (count_q == (IDX_WIDTH+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/rob_retire.sv
// rtl/rob_retire.sv - in-order reorder buffer with retire and free-pool release
module rob_retire #(
    parameter int PREG_WIDTH = rename_pkg::PREG_WIDTH,
    parameter int AREG_WIDTH = rename_pkg::AREG_WIDTH,
    parameter int DEPTH      = rename_pkg::ROB_DEPTH,
    parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic                  alloc_reg_write,
    input  logic [AREG_WIDTH-1:0] alloc_rd,
    input  logic [PREG_WIDTH-1:0] alloc_prd,
    input  logic [PREG_WIDTH-1:0] alloc_old_prd,
    output logic [IDX_WIDTH-1:0]  alloc_idx,
    input  logic                  wb_valid,
    input  logic [IDX_WIDTH-1:0]  wb_idx,
    output logic                  retire_valid,
    output logic [AREG_WIDTH-1:0] retire_rd,
    output logic [PREG_WIDTH-1:0] retire_prd,
    output logic                  free_valid,
    output logic [PREG_WIDTH-1:0] free_preg,
    output logic [IDX_WIDTH:0]    count,
    output logic                  empty,
    output logic                  full
);

    logic                  valid_q     [DEPTH];
    logic                  done_q      [DEPTH];
    logic                  reg_write_q [DEPTH];
    logic [AREG_WIDTH-1:0] rd_q        [DEPTH];
    logic [PREG_WIDTH-1:0] prd_q       [DEPTH];
    logic [PREG_WIDTH-1:0] old_prd_q   [DEPTH];

    logic [IDX_WIDTH-1:0]  head;
    logic [IDX_WIDTH-1:0]  tail;
    logic                  alloc_fire;
    logic                  retire_fire;
    logic                  frees;

    logic                  retire_valid_q;
    logic [AREG_WIDTH-1:0] retire_rd_q;
    logic [PREG_WIDTH-1:0] retire_prd_q;
    logic                  free_valid_q;
    logic [PREG_WIDTH-1:0] free_preg_q;

    // Both decisions look only at pre-edge state, so a retire never frees a slot for a same-cycle alloc.
    assign alloc_fire  = alloc_valid && !full;
    assign retire_fire = valid_q[head] && done_q[head];
    // Writes to the zero register never took a new preg, so nothing goes back to the pool.
    assign frees       = reg_write_q[head] && (rd_q[head] != '0);

    rob_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_ptr (
        .clk         (clk),
        .rst         (rst),
        .alloc_fire  (alloc_fire),
        .retire_fire (retire_fire),
        .head        (head),
        .tail        (tail),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    // Entry status: wb marks done on live entries, retire clears head, alloc opens tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
            end
        end else begin
            if (wb_valid && valid_q[wb_idx]) done_q[wb_idx] <= 1'b1;
            if (retire_fire) begin
                valid_q[head] <= 1'b0;
                done_q[head]  <= 1'b0;
            end
            if (alloc_fire) begin
                valid_q[tail] <= 1'b1;
                done_q[tail]  <= 1'b0;
            end
        end
    end

    // Entry payload is only meaningful while valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            reg_write_q[tail] <= alloc_reg_write;
            rd_q[tail]        <= alloc_rd;
            prd_q[tail]       <= alloc_prd;
            old_prd_q[tail]   <= alloc_old_prd;
        end
    end

    // Single-cycle retire and free pulses; all fields read zero when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_valid_q <= 1'b0;
            retire_rd_q    <= '0;
            retire_prd_q   <= '0;
            free_valid_q   <= 1'b0;
            free_preg_q    <= '0;
        end else begin
            retire_valid_q <= retire_fire;
            retire_rd_q    <= retire_fire ? rd_q[head]  : '0;
            retire_prd_q   <= retire_fire ? prd_q[head] : '0;
            free_valid_q   <= retire_fire && frees;
            free_preg_q    <= (retire_fire && frees) ? old_prd_q[head] : '0;
        end
    end

    assign alloc_ready  = !full;
    assign alloc_idx    = tail;
    assign retire_valid = retire_valid_q;
    assign retire_rd    = retire_rd_q;
    assign retire_prd   = retire_prd_q;
    assign free_valid   = free_valid_q;
    assign free_preg    = free_preg_q;

endmodule

// File: tb/tb_rob_retire.sv
// tb/tb_rob_retire.sv - randomized and directed check of rob_retire against a queue model
module tb_rob_retire;

    localparam int PW = 6;
    localparam int AW = 5;
    localparam int D  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic          alloc_ready;
    logic          alloc_reg_write;
    logic [AW-1:0] alloc_rd;
    logic [PW-1:0] alloc_prd;
    logic [PW-1:0] alloc_old_prd;
    logic [IW-1:0] alloc_idx;
    logic          wb_valid;
    logic [IW-1:0] wb_idx;
    logic          retire_valid;
    logic [AW-1:0] retire_rd;
    logic [PW-1:0] retire_prd;
    logic          free_valid;
    logic [PW-1:0] free_preg;
    logic [IW:0]   count;
    logic          empty;
    logic          full;

    rob_retire #(.PREG_WIDTH(PW), .AREG_WIDTH(AW), .DEPTH(D), .IDX_WIDTH(IW)) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_reg_write (alloc_reg_write),
        .alloc_rd        (alloc_rd),
        .alloc_prd       (alloc_prd),
        .alloc_old_prd   (alloc_old_prd),
        .alloc_idx       (alloc_idx),
        .wb_valid        (wb_valid),
        .wb_idx          (wb_idx),
        .retire_valid    (retire_valid),
        .retire_rd       (retire_rd),
        .retire_prd      (retire_prd),
        .free_valid      (free_valid),
        .free_preg       (free_preg),
        .count           (count),
        .empty           (empty),
        .full            (full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int            idx;
        bit            rw;
        logic [AW-1:0] rd;
        logic [PW-1:0] prd;
        logic [PW-1:0] old;
        bit            done;
    } ment_t;

    ment_t         mq[$];
    int            m_tail;
    logic          exp_rv, exp_fv;
    logic [AW-1:0] exp_rd;
    logic [PW-1:0] exp_prd, exp_fp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_tail = 0;
    endtask

    // One clock: called at negedge, drives inputs, steps the model, checks both sides of the edge.
    task automatic cycle(input bit av, input bit rw, input logic [AW-1:0] rd,
                         input logic [PW-1:0] prd, input logic [PW-1:0] old,
                         input bit wv, input logic [IW-1:0] widx);
        bit    ret;
        bit    acc;
        ment_t e;
        alloc_valid = av; alloc_reg_write = rw; alloc_rd = rd;
        alloc_prd = prd; alloc_old_prd = old; wb_valid = wv; wb_idx = widx;
        #1;
        check("alloc_ready", alloc_ready, mq.size() < D);
        check("alloc_idx", alloc_idx, m_tail);
        check("count", count, mq.size());
        check("empty", empty, mq.size() == 0);
        check("full", full, mq.size() == D);
        ret = (mq.size() > 0) && mq[0].done;
        acc = av && (mq.size() < D);
        exp_rv = ret; exp_rd = '0; exp_prd = '0; exp_fv = 1'b0; exp_fp = '0;
        if (ret) begin
            exp_rd  = mq[0].rd;
            exp_prd = mq[0].prd;
            exp_fv  = mq[0].rw && (mq[0].rd != 0);
            exp_fp  = exp_fv ? mq[0].old : '0;
        end
        if (wv) foreach (mq[i]) if (mq[i].idx == int'(widx)) mq[i].done = 1'b1;
        if (ret) void'(mq.pop_front());
        if (acc) begin
            e.idx = m_tail; e.rw = rw; e.rd = rd; e.prd = prd; e.old = old; e.done = 1'b0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % D;
        end
        @(posedge clk);
        #1;
        check("retire_valid", retire_valid, exp_rv);
        check("retire_rd", retire_rd, exp_rd);
        check("retire_prd", retire_prd, exp_prd);
        check("free_valid", free_valid, exp_fv);
        check("free_preg", free_preg, exp_fp);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, '0, '0, '0, 0, '0);
    endtask

    task automatic alloc(input bit rw, input logic [AW-1:0] rd, input logic [PW-1:0] prd, input logic [PW-1:0] old);
        cycle(1, rw, rd, prd, old, 0, '0);
    endtask

    task automatic wb(input logic [IW-1:0] idx);
        cycle(0, 0, '0, '0, '0, 1, idx);
    endtask

    // Asynchronous reset applied between edges; everything must clear at once and stay quiet.
    task automatic apply_reset();
        alloc_valid = 0; wb_valid = 0;
        rst = 1'b1;
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_alloc_idx", alloc_idx, 0);
        check("rst_retire_valid", retire_valid, 0);
        check("rst_free_valid", free_valid, 0);
        check("rst_free_preg", free_preg, 0);
        @(posedge clk);
        #1;
        check("rst_hold_retire_valid", retire_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        rst = 1'b1;
        alloc_valid = 0; alloc_reg_write = 0; alloc_rd = '0; alloc_prd = '0;
        alloc_old_prd = '0; wb_valid = 0; wb_idx = '0;
        model_clear();
        @(negedge clk);
        apply_reset();

        // Single instruction end to end.
        alloc(1, 5'd5, 6'd32, 6'd5);
        wb(0);
        idle(1);
        check("t1_retire_valid", retire_valid, 1);
        check("t1_retire_rd", retire_rd, 5);
        check("t1_retire_prd", retire_prd, 32);
        check("t1_free_valid", free_valid, 1);
        check("t1_free_preg", free_preg, 5);
        check("t1_count", count, 0);
        idle(1);

        // Reverse-order writeback still retires in program order.
        apply_reset();
        alloc(1, 5'd1, 6'd40, 6'd1);
        alloc(1, 5'd2, 6'd41, 6'd2);
        alloc(1, 5'd3, 6'd42, 6'd3);
        wb(2);
        wb(1);
        idle(1);
        check("t2_no_retire", retire_valid, 0);
        check("t2_count", count, 3);
        wb(0);
        idle(1);
        check("t2_first_rd", retire_rd, 1);
        idle(3);

        // Fill, overflow attempt, retire and wrap.
        apply_reset();
        for (int i = 0; i < D; i++) alloc(1, AW'(i + 1), PW'(i + 20), PW'(i + 1));
        check("t3_full", full, 1);
        check("t3_alloc_ready", alloc_ready, 0);
        alloc(1, 5'd9, 6'd9, 6'd9);
        check("t3_count_17th", count, 16);
        check("t3_tail_17th", alloc_idx, 0);
        wb(0);
        alloc(1, 5'd9, 6'd9, 6'd9);
        check("t3_count_after_retire", count, 15);
        check("t3_not_full", full, 0);
        check("t3_wrap_idx", alloc_idx, 0);
        alloc(1, 5'd10, 6'd50, 6'd10);
        check("t3_refill", count, 16);

        // No free for rd=0 or non-writing instructions.
        apply_reset();
        alloc(1, 5'd0, 6'd33, 6'd7);
        alloc(0, 5'd4, 6'd34, 6'd8);
        wb(0);
        wb(1);
        check("t4_rv", retire_valid, 1);
        check("t4_fv", free_valid, 0);
        idle(2);

        // Writeback to an invalid entry must not pre-complete a later allocation.
        apply_reset();
        for (int i = 0; i < 7; i++) alloc(1, AW'(i + 1), PW'(i), PW'(i + 8));
        wb(7);
        alloc(1, 5'd17, 6'd60, 6'd61);
        for (int i = 0; i < 7; i++) wb(IW'(i));
        idle(4);
        check("t5_stuck_entry", count, 1);
        wb(7);
        idle(2);

        // Reset while completed entries wait at the head.
        apply_reset();
        for (int i = 0; i < 5; i++) alloc(1, AW'(i + 2), PW'(i + 10), PW'(i + 2));
        wb(1);
        wb(0);
        apply_reset();
        idle(2);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 3000; n++) begin
            bit            av, wv;
            logic [IW-1:0] widx;
            av = ($urandom_range(0, 99) < 60);
            wv = ($urandom_range(0, 99) < 70);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                widx = IW'(mq[$urandom_range(0, mq.size() - 1)].idx);
            else
                widx = IW'($urandom_range(0, D - 1));
            if ($urandom_range(0, 599) == 0) apply_reset();
            else cycle(av, 1'($urandom), AW'($urandom_range(0, 31)),
                       PW'($urandom), PW'($urandom), wv, widx);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
